cmd_loader: RTL and testbench



---
 rtl/gpu2d_pkg.sv | 28 ++
 rtl/uart_rx.sv | 114 +++++++++++
 rtl/cmd_loader.sv | 183 ++++++++++++++++++
 tb/tb_cmd_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu2d_pkg.sv
// gpu2d_pkg
// Shared definitions for the 2D GPU command path (cmd_loader, cbram, renderer).
// Contents:
//   CB_ADDR_W          - command-buffer RAM address width
//   SYNC_BYTE_DEFAULT  - default frame start marker
//   cmd_loader_state_t - frame-level FSM states of cmd_loader
//   uart_rx_state_t    - bit-level states of the UART receiver
package gpu2d_pkg;

  localparam int CB_ADDR_W = 10;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    PAYLOAD,
    CHECK
  } cmd_loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// uart_rx
// 8N1 UART receiver running in the renderer clock domain.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   rx         - serial input, idle high, asynchronous to clk
//   rx_byte    - last received byte, valid when byte_valid pulses
//   byte_valid - one-cycle pulse: byte received with a good stop bit
//   byte_ferr  - one-cycle pulse: byte received with a low stop bit
module uart_rx
  import gpu2d_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       byte_ferr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]     sync;
  logic           rx_s;
  logic           rx_prev;
  uart_rx_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]     bit_idx, bit_idx_n;
  logic [7:0]     shreg, shreg_n;
  logic           valid_n, ferr_n;

  assign rx_s    = sync[1];
  assign rx_byte = shreg;

  // Two-flop synchronizer for the asynchronous line, plus one more flop so
  // a start bit is recognised only on a genuine high-to-low transition and
  // a line stuck low after a framing error does not retrigger reception.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], rx};
      rx_prev <= rx_s;
    end
  end

  // Receiver state, bit timer, shift register and the registered strobes.
  // The strobes are registered, so they appear one cycle after the stop-bit
  // centre.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_ferr  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      byte_valid <= valid_n;
      byte_ferr  <= ferr_n;
    end
  end

  // Bit sequencing: wait half a bit to reach the start-bit centre, then one
  // full bit per data bit (LSB first), then one more for the stop bit.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (rx_prev && !rx_s) state_n = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_n     = '0;
          shreg_n   = {rx_s, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_n   = '0;
          valid_n = rx_s;
          ferr_n  = !rx_s;
          state_n = RX_IDLE;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/cmd_loader.sv
// cmd_loader
// Receives framed command-buffer images over UART and writes the payload
// sequentially into port B of cbram, starting at address 0.
// Frame: SYNC_BYTE, LEN_LO, LEN_HI, LEN payload bytes, XOR of payload.
// Optional build macro: CMD_LOADER_TIMEOUT_EN aborts a frame that stalls
// for 20*CLKS_PER_BIT*10 cycles without a received byte.
// Ports:
//   clk, rst    - clock (rising edge), asynchronous active-high reset
//   rx          - UART serial input
//   cb_we       - cbram port-B write enable (one cycle per payload byte)
//   cb_addr     - cbram port-B address (held when cb_we=0)
//   cb_d        - cbram port-B write data (held when cb_we=0)
//   busy        - high while a frame is in progress
//   frame_done  - one-cycle pulse: frame accepted, checksum good
//   frame_err   - one-cycle pulse: frame aborted
//   frame_count - number of accepted frames, wrapping
module cmd_loader
  import gpu2d_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         ADDR_W       = CB_ADDR_W,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              cb_we,
  output logic [ADDR_W-1:0] cb_addr,
  output logic [7:0]        cb_d,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [15:0]       frame_count
);

  localparam int unsigned MAX_LEN = 2 ** ADDR_W;

  logic [7:0]  rx_byte;
  logic        byte_valid, byte_ferr;
  logic        timeout;

  cmd_loader_state_t state, state_n;
  logic [7:0]        len_lo, len_lo_n;
  logic [15:0]       len_q, len_q_n;
  logic [15:0]       len_full;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [7:0]        xor_acc, xor_acc_n;
  logic [16:0]       wr_num;
  logic              cb_we_n, done_n, err_n;
  logic [ADDR_W-1:0] cb_addr_n;
  logic [7:0]        cb_d_n;
  logic [15:0]       frame_count_n;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .byte_ferr  (byte_ferr)
  );

  assign busy     = (state != IDLE);
  assign len_full = {rx_byte, len_lo};
  assign wr_num   = 17'(addr) + 17'd1;

`ifdef CMD_LOADER_TIMEOUT_EN
  localparam logic [23:0] TIMEOUT_CYCLES = 24'(20 * CLKS_PER_BIT * 10);
  logic [23:0] idle_cnt;

  // Idle counter measures the gap since the last received byte while a
  // frame is open; any byte event (good or bad) restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (!busy || byte_valid || byte_ferr) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 24'd1;
    end
  end

  assign timeout = busy && (idle_cnt == TIMEOUT_CYCLES - 24'd1);
`else
  assign timeout = 1'b0;
`endif

  // Frame state and all output registers. Outputs are registered so the
  // write for a payload byte lands in the cycle after its byte_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      len_lo      <= '0;
      len_q       <= '0;
      addr        <= '0;
      xor_acc     <= '0;
      cb_we       <= 1'b0;
      cb_addr     <= '0;
      cb_d        <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_n;
      len_lo      <= len_lo_n;
      len_q       <= len_q_n;
      addr        <= addr_n;
      xor_acc     <= xor_acc_n;
      cb_we       <= cb_we_n;
      cb_addr     <= cb_addr_n;
      cb_d        <= cb_d_n;
      frame_done  <= done_n;
      frame_err   <= err_n;
      frame_count <= frame_count_n;
    end
  end

  // Frame parser. A framing error aborts any open frame; a good byte
  // advances the frame; a stall timeout (if built in) aborts only when no
  // byte arrived that cycle. Nothing in IDLE ever raises a pulse.
  always_comb begin
    state_n       = state;
    len_lo_n      = len_lo;
    len_q_n       = len_q;
    addr_n        = addr;
    xor_acc_n     = xor_acc;
    cb_we_n       = 1'b0;
    cb_addr_n     = cb_addr;
    cb_d_n        = cb_d;
    done_n        = 1'b0;
    err_n         = 1'b0;
    frame_count_n = frame_count;
    if (byte_ferr) begin
      if (state != IDLE) begin
        err_n   = 1'b1;
        state_n = IDLE;
      end
    end else if (byte_valid) begin
      case (state)
        IDLE: begin
          if (rx_byte == SYNC_BYTE) state_n = LEN_LO;
        end
        LEN_LO: begin
          len_lo_n = rx_byte;
          state_n  = LEN_HI;
        end
        LEN_HI: begin
          if ((len_full == 16'd0) || (32'(len_full) > MAX_LEN)) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            len_q_n   = len_full;
            addr_n    = '0;
            xor_acc_n = '0;
            state_n   = PAYLOAD;
          end
        end
        PAYLOAD: begin
          cb_we_n   = 1'b1;
          cb_addr_n = addr;
          cb_d_n    = rx_byte;
          xor_acc_n = xor_acc ^ rx_byte;
          addr_n    = addr + 1'b1;
          if (wr_num == {1'b0, len_q}) state_n = CHECK;
        end
        CHECK: begin
          if (rx_byte == xor_acc) begin
            done_n        = 1'b1;
            frame_count_n = frame_count + 16'd1;
          end else begin
            err_n = 1'b1;
          end
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if (timeout) begin
      err_n   = 1'b1;
      state_n = IDLE;
    end
  end

endmodule

// File: tb/tb_cmd_loader.sv
// tb_cmd_loader
// Self-checking bench for cmd_loader: a table of fixed frames, randomized
// frame streams checked against a stream-level frame parser model, and
// hand-written sequences for framing error, stall and mid-frame reset.
// A reduced ADDR_W keeps the maximum-length frame short in simulation time.
module tb_cmd_loader;

  localparam int CPB     = 16;
  localparam int AW      = 7;
  localparam int MAX_LEN = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic          cb_we;
  logic [AW-1:0] cb_addr;
  logic [7:0]    cb_d;
  logic          busy, frame_done, frame_err;
  logic [15:0]   frame_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] stim_q[$];
  int exp_addr[$], exp_data[$];
  int exp_done, exp_err;
  int exp_count = 0;

  int obs_addr[$], obs_data[$];
  int obs_done = 0, obs_err = 0, obs_both = 0, obs_busy_done = 0;

  typedef struct packed {
    logic [0:7][7:0] b;
    logic [31:0]     n;
    logic [31:0]     w;
    logic [31:0]     d;
    logic [31:0]     e;
  } vec_t;

  vec_t tbl [6];

  cmd_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .cb_we       (cb_we),
    .cb_addr     (cb_addr),
    .cb_d        (cb_d),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  // Passive monitor on the falling edge: records every write cycle and
  // every status pulse for later comparison.
  always @(negedge clk) begin
    if (cb_we) begin
      obs_addr.push_back(int'(cb_addr));
      obs_data.push_back(int'(cb_d));
    end
    if (frame_done) begin
      obs_done++;
      if (busy) obs_busy_done++;
    end
    if (frame_err) obs_err++;
    if (frame_done && frame_err) obs_both++;
  end

  task automatic checkOutput(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic bit_wait();
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    bit_wait();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      bit_wait();
    end
    rx = stop_bit;
    bit_wait();
    rx = 1'b1;
    if (!stop_bit) begin
      bit_wait();
      bit_wait();
    end
  endtask

  task automatic applyStimulus();
    foreach (stim_q[i]) send_byte(stim_q[i], 1'b1);
    repeat (4 * CPB) @(negedge clk);
  endtask

  task automatic clear_obs();
    @(negedge clk);
    #1;
    obs_addr.delete();
    obs_data.delete();
    obs_done = 0;
    obs_err = 0;
    obs_both = 0;
    obs_busy_done = 0;
  endtask

  // Stream-level reference: scan for the marker, read a little-endian
  // length, reject illegal lengths, then payload goes to addresses 0.. and
  // the byte after it must equal the XOR of the payload.
  function automatic void run_model();
    int i, n, len;
    logic [7:0] x;
    i = 0;
    n = stim_q.size();
    exp_addr.delete();
    exp_data.delete();
    exp_done = 0;
    exp_err = 0;
    while (i < n) begin
      if (stim_q[i] != 8'hA5 || i + 2 >= n) begin
        i++;
        continue;
      end
      len = int'(stim_q[i+1]) + 256 * int'(stim_q[i+2]);
      i += 3;
      if (len == 0 || len > MAX_LEN) begin
        exp_err++;
        continue;
      end
      x = 8'h00;
      for (int k = 0; k < len && i < n; k++) begin
        exp_addr.push_back(k);
        exp_data.push_back(int'(stim_q[i]));
        x ^= stim_q[i];
        i++;
      end
      if (i < n) begin
        if (stim_q[i] == x) exp_done++;
        else exp_err++;
        i++;
      end
    end
  endfunction

  task automatic checkScenario(input string tag);
    checkOutput({tag, " write count"}, obs_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checkOutput($sformatf("%s addr[%0d]", tag, i), obs_addr[i], exp_addr[i]);
      checkOutput($sformatf("%s data[%0d]", tag, i), obs_data[i], exp_data[i]);
    end
    exp_count = (exp_count + exp_done) % 65536;
    checkOutput({tag, " done pulses"}, obs_done, exp_done);
    checkOutput({tag, " err pulses"}, obs_err, exp_err);
    checkOutput({tag, " frame_count"}, int'(frame_count), exp_count);
    checkOutput({tag, " busy after"}, int'(busy), 0);
    checkOutput({tag, " done&err overlap"}, obs_both, 0);
    checkOutput({tag, " busy at done"}, obs_busy_done, 0);
  endtask

  function automatic vec_t mk(input logic [63:0] bytes, input int n, input int w,
                              input int d, input int e);
    vec_t v;
    v.b = bytes;
    v.n = n;
    v.w = w;
    v.d = d;
    v.e = e;
    return v;
  endfunction

  initial begin
    logic [7:0] x;
    int len, kind;

    tbl[0] = mk({8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00}, 7, 3, 1, 0);
    tbl[1] = mk({8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h01, 8'h00}, 7, 3, 0, 1);
    tbl[2] = mk({8'h00, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h7E, 8'h7E, 8'h00}, 7, 1, 1, 0);
    tbl[3] = mk({8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 0, 0, 1);
    tbl[4] = mk({8'hA5, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 0, 0, 1);
    tbl[5] = mk({8'hA5, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 0, 0, 1);

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset cb_we", int'(cb_we), 0);
    checkOutput("reset cb_addr", int'(cb_addr), 0);
    checkOutput("reset cb_d", int'(cb_d), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset pulses", int'({frame_done, frame_err}), 0);
    checkOutput("reset frame_count", int'(frame_count), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Fixed vectors
    for (int t = 0; t < 6; t++) begin
      clear_obs();
      stim_q.delete();
      for (int i = 0; i < int'(tbl[t].n); i++) stim_q.push_back(tbl[t].b[i]);
      run_model();
      applyStimulus();
      checkOutput($sformatf("vec%0d writes", t), obs_addr.size(), int'(tbl[t].w));
      checkOutput($sformatf("vec%0d done", t), obs_done, int'(tbl[t].d));
      checkOutput($sformatf("vec%0d err", t), obs_err, int'(tbl[t].e));
      checkScenario($sformatf("vec%0d", t));
    end

    // Maximum-length frame
    clear_obs();
    stim_q.delete();
    stim_q.push_back(8'hA5);
    stim_q.push_back(8'(MAX_LEN & 255));
    stim_q.push_back(8'(MAX_LEN >> 8));
    x = 8'h00;
    for (int i = 0; i < MAX_LEN; i++) begin
      stim_q.push_back(8'($urandom_range(0, 255)));
      x ^= stim_q[$];
    end
    stim_q.push_back(x);
    run_model();
    applyStimulus();
    if (obs_addr.size() > 0) checkOutput("maxlen last addr", obs_addr[$], MAX_LEN - 1);
    else checkOutput("maxlen any write", 0, 1);
    checkScenario("maxlen");

    // Randomized streams of junk and frames
    for (int r = 0; r < 6; r++) begin
      clear_obs();
      stim_q.delete();
      for (int j = 0; j < 3; j++) begin
        for (int k = $urandom_range(0, 2); k > 0; k--) begin
          x = 8'($urandom_range(0, 255));
          stim_q.push_back((x == 8'hA5) ? 8'h5A : x);
        end
        stim_q.push_back(8'hA5);
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
          len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 65535);
          stim_q.push_back(8'(len & 255));
          stim_q.push_back(8'(len >> 8));
        end else begin
          len = $urandom_range(1, 10);
          stim_q.push_back(8'(len));
          stim_q.push_back(8'h00);
          x = 8'h00;
          for (int k = 0; k < len; k++) begin
            stim_q.push_back(8'($urandom_range(0, 255)));
            x ^= stim_q[$];
          end
          if (kind < 4) x ^= 8'(1 << $urandom_range(0, 7));
          stim_q.push_back(x);
        end
      end
      run_model();
      applyStimulus();
      checkScenario($sformatf("rand%0d", r));
    end

    // Bad stop bit on the second payload byte, then a good frame
    clear_obs();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    checkOutput("ferr writes", obs_addr.size(), 1);
    if (obs_addr.size() > 0) begin
      checkOutput("ferr addr0", obs_addr[0], 0);
      checkOutput("ferr data0", obs_data[0], 8'h11);
    end
    checkOutput("ferr err pulses", obs_err, 1);
    checkOutput("ferr done pulses", obs_done, 0);
    checkOutput("ferr busy", int'(busy), 0);
    clear_obs();
    stim_q = '{8'hA5, 8'h02, 8'h00, 8'h5C, 8'h3B, 8'h67};
    run_model();
    applyStimulus();
    checkScenario("after ferr");

    // Stalled frame
    clear_obs();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    repeat (20 * CPB * 10 + 200) @(negedge clk);
`ifdef CMD_LOADER_TIMEOUT_EN
    checkOutput("timeout err pulses", obs_err, 1);
    checkOutput("timeout busy", int'(busy), 0);
    checkOutput("timeout writes", obs_addr.size(), 1);
    checkOutput("timeout frame_count", int'(frame_count), exp_count);
`else
    checkOutput("stall busy", int'(busy), 1);
    checkOutput("stall err pulses", obs_err, 0);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    repeat (4 * CPB) @(negedge clk);
    exp_count = (exp_count + 1) % 65536;
    checkOutput("stall writes", obs_addr.size(), 2);
    checkOutput("stall done pulses", obs_done, 1);
    checkOutput("stall frame_count", int'(frame_count), exp_count);
`endif

    // Reset during payload
    clear_obs();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("pre-reset busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    checkOutput("midreset cb_we", int'(cb_we), 0);
    checkOutput("midreset cb_addr", int'(cb_addr), 0);
    checkOutput("midreset cb_d", int'(cb_d), 0);
    checkOutput("midreset busy", int'(busy), 0);
    checkOutput("midreset frame_count", int'(frame_count), 0);
    repeat (3) @(negedge clk);
    checkOutput("midreset err pulses", obs_err, 0);
    rst = 1'b0;
    exp_count = 0;
    repeat (4) @(negedge clk);
    clear_obs();
    stim_q = '{8'hA5, 8'h01, 8'h00, 8'h7E, 8'h7E};
    run_model();
    applyStimulus();
    checkScenario("after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
